// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver. The serial line is synchronized, a start bit is detected
// on a falling edge, and the start, eight data bits (LSB first) and stop bit
// are each sampled near their midpoint.
//
// Parameters:
//   CLKS_PER_BIT     clk cycles per serial bit (4 or more)
//
// Ports:
//   clk              system clock, rising edge
//   i_Rst_L          asynchronous active-low reset
//   i_RX_Serial      serial line, idle high
//   o_RX_Data_Valid  one-cycle strobe, good byte received
//   o_RX_Byte        last good byte, updated with o_RX_Data_Valid
//   o_Framing_Err    one-cycle strobe, stop bit sampled low
//   o_RX_Busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       i_Rst_L,
   input  logic       i_RX_Serial,
   output logic       o_RX_Data_Valid,
   output logic [7:0] o_RX_Byte,
   output logic       o_Framing_Err,
   output logic       o_RX_Busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            prev_q, prev_d;
   logic [1:0]      fill_q, fill_d;
   logic            armed_q, armed_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      byte_q, byte_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            fall_edge;

   // The synchronizer flops come out of reset high, so a line that is already
   // low when reset is released would look like a falling edge. fill_q tracks
   // when sync2_q holds a genuine sample; armed_q is set once the line has
   // really been seen high, and only then are start edges accepted.
   assign fall_edge = armed_q & prev_q & ~sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      sync1_d = i_RX_Serial;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      fill_d  = {fill_q[0], 1'b1};
      armed_d = armed_q | (fill_q[1] & sync2_q);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall_edge) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!sync2_q) begin
                  state_d = DATA;
                  idx_d   = 3'd0;
               end else begin
                  // Line back high at mid start bit: glitch, not a frame.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = sync2_q;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (sync2_q) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         fill_q  <= 2'b00;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         fill_q  <= fill_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign o_RX_Data_Valid = valid_q;
   assign o_RX_Byte       = byte_q;
   assign o_Framing_Err   = err_q;
   assign o_RX_Busy       = (state_q != IDLE);

endmodule
